msg_unpacker: RTL and testbench

//  Receiving end of the debug message stream (msg / msg_nd) emitted by datapath blocks.

---
 rtl/msg_unpacker_pkg.sv | 37 +++
 rtl/msg_unpacker_buffer.sv | 51 +++++
 rtl/msg_unpacker.sv | 206 ++++++++++++++++++++
 tb/tb_msg_unpacker.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_unpacker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msg_unpacker_pkg
//  Description : Shared definitions for the debug message unpacker: default
//                widths, header-flag bit position, fault codes and the
//                unpacker state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package msg_unpacker_pkg;

  localparam int MSG_WIDTH_DEF  = 32;
  localparam int LEN_WIDTH_DEF  = 8;
  localparam int MAX_LEN_DEF    = 64;
  localparam int ADDR_WIDTH_DEF = 6;

  // Fault codes reported on err_code (value of the most recent fault).
  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_ORPHAN = 2'd1,  // payload word with no open message
    ERR_TRUNC  = 2'd2,  // header arrived before the previous message completed
    ERR_LONG   = 2'd3   // header length too large, or header arrived while replaying
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_SKIP    = 2'd3
  } state_e;

  // The header flag is the MSB of every message word.
  function automatic int hdr_flag_idx(input int msg_width);
    return msg_width - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msg_unpacker_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : msg_unpacker_buffer
//  Description : Simple dual-port payload store. Synchronous write, registered
//                read. A write and a read of the same address on the same edge
//                return the new data, so a one-word message can be replayed
//                the cycle after its only word is written.
//  Ports       : clk, rst      - clock, async active-high reset (read reg only)
//                we_i          - write enable
//                waddr_i/wdata_i - write address / data
//                raddr_i       - read address (sampled every edge)
//                rdata_o       - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_unpacker_buffer #(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (we_i && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/msg_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : msg_unpacker
//  Description : Receives framed debug messages (header word carrying a
//                length, then that many payload words), buffers a complete
//                message and replays it over a valid/ready interface. Framing
//                faults raise a sticky error flag with a fault code.
//  Ports       : clk, rst             - clock, async active-high reset
//                in_msg, in_msg_nd    - input word (MSB=1 header) and strobe
//                out_data/out_valid/out_ready - replay handshake
//                out_first/out_last   - first / last word qualifiers
//                out_len              - length of the message being replayed
//                error, err_code      - sticky fault flag, most recent code
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_unpacker
  import msg_unpacker_pkg::*;
#(
  parameter int MSG_WIDTH  = MSG_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MSG_WIDTH-1:0] in_msg,
  input  logic                 in_msg_nd,
  output logic [MSG_WIDTH-2:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_first,
  output logic                 out_last,
  output logic [LEN_WIDTH-1:0] out_len,
  output logic                 error,
  output logic [1:0]           err_code
);

  localparam int                   HDR_IDX   = hdr_flag_idx(MSG_WIDTH);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);

  state_e                 state_q,    state_d;
  logic [ADDR_WIDTH-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [LEN_WIDTH-1:0]   remain_q,   remain_d;
  logic [LEN_WIDTH-1:0]   skip_q,     skip_d;
  logic [LEN_WIDTH-1:0]   len_q,      len_d;
  logic                   error_q,    error_d;
  err_code_e              err_code_q, err_code_d;

  logic                   buf_we;
  logic [MSG_WIDTH-2:0]   buf_rdata;

  logic                   w_is_hdr;
  logic                   w_is_pay;
  logic [LEN_WIDTH-1:0]   w_hdr_len;
  logic                   w_fire;
  logic                   w_at_last;

  assign w_is_hdr  = in_msg_nd &  in_msg[HDR_IDX];
  assign w_is_pay  = in_msg_nd & ~in_msg[HDR_IDX];
  assign w_hdr_len = in_msg[LEN_WIDTH-1:0];
  assign w_fire    = out_valid & out_ready;
  assign w_at_last = (LEN_WIDTH'(rd_ptr_q) == (len_q - LEN_WIDTH'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      remain_q   <= '0;
      skip_q     <= '0;
      len_q      <= '0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      remain_q   <= remain_d;
      skip_q     <= skip_d;
      len_q      <= len_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    remain_d   = remain_q;
    skip_d     = skip_q;
    len_d      = len_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    buf_we     = 1'b0;

    if (w_is_hdr && (state_q != ST_DRAIN)) begin
      // A header outside replay always opens a fresh frame. If a frame or a
      // skip was in progress it is abandoned (truncation); a too-long header
      // then overrides that with its own code, as the most recent fault.
      if (state_q != ST_IDLE) begin
        error_d    = 1'b1;
        err_code_d = ERR_TRUNC;
      end
      skip_d   = '0;
      rd_ptr_d = '0;
      if (w_hdr_len == '0) begin
        state_d = ST_IDLE;
      end else if (w_hdr_len > MAX_LEN_L) begin
        state_d    = ST_SKIP;
        skip_d     = w_hdr_len;
        error_d    = 1'b1;
        err_code_d = ERR_LONG;
      end else begin
        state_d  = ST_COLLECT;
        wr_ptr_d = '0;
        remain_d = w_hdr_len;
        len_d    = w_hdr_len;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_is_pay) begin
            error_d    = 1'b1;
            err_code_d = ERR_ORPHAN;
          end
        end

        ST_COLLECT: begin
          if (w_is_pay) begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            remain_d = remain_q - LEN_WIDTH'(1);
            if (remain_q == LEN_WIDTH'(1)) begin
              state_d  = ST_DRAIN;
              rd_ptr_d = '0;
            end
          end
        end

        ST_DRAIN: begin
          // Input cannot be buffered while replaying: a header arms the skip
          // counter so its payload is swallowed, even past the end of replay.
          if (w_is_hdr) begin
            skip_d     = w_hdr_len;
            error_d    = 1'b1;
            err_code_d = ERR_LONG;
          end else if (w_is_pay) begin
            if (skip_q != '0) begin
              skip_d = skip_q - LEN_WIDTH'(1);
            end else begin
              error_d    = 1'b1;
              err_code_d = ERR_ORPHAN;
            end
          end
          if (w_fire) begin
            if (w_at_last) begin
              rd_ptr_d = '0;
              state_d  = (skip_d != '0) ? ST_SKIP : ST_IDLE;
            end else begin
              rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            end
          end
        end

        ST_SKIP: begin
          if (w_is_pay) begin
            skip_d = skip_q - LEN_WIDTH'(1);
            if (skip_q == LEN_WIDTH'(1)) begin
              state_d = ST_IDLE;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Read address is the next read pointer so the registered read data lines
  // up with rd_ptr_q, and holds while the consumer stalls.
  msg_unpacker_buffer #(
    .DEPTH      (MAX_LEN),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (MSG_WIDTH - 1)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .we_i    (buf_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_msg[MSG_WIDTH-2:0]),
    .raddr_i (rd_ptr_d),
    .rdata_o (buf_rdata)
  );

  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = out_valid ? buf_rdata : '0;
  assign out_first = out_valid & (rd_ptr_q == '0);
  assign out_last  = out_valid & w_at_last;
  assign out_len   = len_q;
  assign error     = error_q;
  assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_msg_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msg_unpacker
//  Description : Self-checking bench for msg_unpacker. A queue-based model of
//                the message stream predicts replayed words and fault codes;
//                directed scenarios pin the model with literal expectations,
//                then a long randomized stream runs against the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msg_unpacker;

  localparam int MAX_LEN = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_msg;
  logic        in_msg_nd;
  logic [30:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_first;
  logic        out_last;
  logic [7:0]  out_len;
  logic        error;
  logic [1:0]  err_code;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 never

  msg_unpacker dut (
    .clk       (clk),
    .rst       (rst),
    .in_msg    (in_msg),
    .in_msg_nd (in_msg_nd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last),
    .out_len   (out_len),
    .error     (error),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [30:0] m_part[$];   // words of the message being assembled
  bit          m_coll;
  int          m_need;
  int          m_skip;
  logic [30:0] m_rep[$];    // words still to be replayed
  int          m_rep_idx;
  int          m_rep_len;
  bit          m_err;
  int          m_code;

  task automatic m_fault(input int c);
    m_err  = 1'b1;
    m_code = c;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_part.delete(); m_rep.delete();
      m_coll = 0; m_need = 0; m_skip = 0;
      m_rep_idx = 0; m_rep_len = 0; m_err = 0; m_code = 0;
    end else begin
      bit draining;
      bit fire;
      draining = (m_rep.size() > 0);
      fire     = draining && out_ready;
      if (in_msg_nd) begin
        int len;
        len = int'(in_msg[7:0]);
        if (draining) begin
          if (in_msg[31]) begin
            m_fault(3);
            m_skip = len;
          end else if (m_skip > 0) m_skip--;
          else m_fault(1);
        end else if (in_msg[31]) begin
          if (m_coll || m_skip > 0) m_fault(2);
          m_part.delete();
          m_coll = 0;
          m_skip = 0;
          if (len > MAX_LEN) begin
            m_fault(3);
            m_skip = len;
          end else if (len > 0) begin
            m_coll = 1;
            m_need = len;
          end
        end else begin
          if (m_coll) begin
            m_part.push_back(in_msg[30:0]);
            if (m_part.size() == m_need) begin
              m_rep     = m_part;
              m_rep_len = m_need;
              m_rep_idx = 0;
              m_part.delete();
              m_coll = 0;
            end
          end else if (m_skip > 0) m_skip--;
          else m_fault(1);
        end
      end
      if (fire) begin
        void'(m_rep.pop_front());
        m_rep_idx++;
      end
    end
  end

  // ---------------- compare process ----------------
  typedef struct {
    logic [30:0] d;
    logic        f;
    logic        l;
    logic [7:0]  len;
  } ent_t;
  ent_t        dut_log[$];
  logic [30:0] exp_q[$];

  bit          p_stall = 0;
  logic [30:0] p_data;
  logic        p_first, p_last;

  always @(negedge clk) begin
    if (rst) begin
      p_stall = 0;
    end else begin
      check("valid", out_valid, m_rep.size() > 0);
      if (m_rep.size() > 0) begin
        check("data",  out_data,  m_rep[0]);
        check("first", out_first, m_rep_idx == 0);
        check("last",  out_last,  m_rep.size() == 1);
        check("len",   out_len,   m_rep_len);
      end
      check("error",    error,    m_err);
      check("err_code", err_code, m_code);
      if (p_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data",  out_data,  p_data);
        check("stall_first", out_first, p_first);
        check("stall_last",  out_last,  p_last);
      end
      p_stall = out_valid && !out_ready;
      p_data  = out_data;
      p_first = out_first;
      p_last  = out_last;
      if (out_valid && out_ready) begin
        ent_t e;
        e.d = out_data; e.f = out_first; e.l = out_last; e.len = out_len;
        dut_log.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input logic [31:0] w);
    @(posedge clk); #1;
    in_msg = w; in_msg_nd = 1'b1;
  endtask

  task automatic put_idle();
    @(posedge clk); #1;
    in_msg = '0; in_msg_nd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put_idle();
  endtask

  function automatic logic [31:0] hdr(input int len);
    logic [22:0] junk;
    junk = 23'($urandom);
    return {1'b1, junk, 8'(len)};
  endfunction

  function automatic logic [31:0] pay(input logic [30:0] d);
    return {1'b0, d};
  endfunction

  function automatic int rand_len();
    int r;
    r = $urandom_range(0, 99);
    if (r < 5)  return 0;
    if (r < 85) return $urandom_range(1, 8);
    if (r < 95) return $urandom_range(60, 66);
    return $urandom_range(67, 255);
  endfunction

  // Literal check of what the DUT handed over since the last call: every
  // logged run here is a single message, so first/last/len follow position.
  task automatic check_log(input string name);
    int n;
    n = exp_q.size();
    check({name, "_count"}, dut_log.size(), n);
    for (int i = 0; i < n && i < dut_log.size(); i++) begin
      check({name, "_data"},  dut_log[i].d,   exp_q[i]);
      check({name, "_first"}, dut_log[i].f,   i == 0);
      check({name, "_last"},  dut_log[i].l,   i == n - 1);
      check({name, "_len"},   dut_log[i].len, n);
    end
    dut_log.delete();
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; in_msg = '0; in_msg_nd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",    out_valid, 0);
    check("rst_data",     out_data,  0);
    check("rst_first",    out_first, 0);
    check("rst_last",     out_last,  0);
    check("rst_len",      out_len,   0);
    check("rst_error",    error,     0);
    check("rst_err_code", err_code,  0);
    rst = 1'b0;

    // 1: basic three-word message, one-cycle replay latency
    put(hdr(3)); put(pay(31'h0A)); put(pay(31'h0B)); put(pay(31'h0C));
    @(negedge clk);
    check("t1_pre_valid", out_valid, 0);
    put_idle();
    @(negedge clk);
    check("t1_lat_valid", out_valid, 1);
    check("t1_lat_data",  out_data,  31'h0A);
    check("t1_lat_first", out_first, 1);
    check("t1_lat_len",   out_len,   3);
    idle(6);
    exp_q = '{31'h0A, 31'h0B, 31'h0C};
    check_log("t1");
    check("t1_error", error, 0);

    // 2: consumer toggling ready
    rdy_mode = 1;
    put(hdr(3)); put(pay(31'h1111)); put(pay(31'h2222)); put(pay(31'h3333));
    idle(12);
    exp_q = '{31'h1111, 31'h2222, 31'h3333};
    check_log("t2");
    rdy_mode = 0;

    // 3: truncated message followed by a one-word message
    put(hdr(4)); put(pay(31'h51)); put(pay(31'h52));
    put(hdr(1)); put(pay(31'h0D));
    idle(5);
    check("t3_error",    error,    1);
    check("t3_err_code", err_code, 2);
    exp_q = '{31'h0D};
    check_log("t3");

    // 4: orphan payload, then zero-length header
    put(pay(31'h0E));
    idle(2);
    check("t4_err_code", err_code, 1);
    put(hdr(0));
    idle(4);
    check("t4_err_code_hold", err_code, 1);
    check_log("t4");

    // 5: over-long header and its words are skipped, then a good message
    put(hdr(MAX_LEN + 1));
    for (int i = 0; i < MAX_LEN + 1; i++) put(pay(31'(i + 100)));
    idle(2);
    check("t5_err_code", err_code, 3);
    check("t5_valid",    out_valid, 0);
    check_log("t5_skip");
    put(hdr(2)); put(pay(31'h7A)); put(pay(31'h7B));
    idle(5);
    exp_q = '{31'h7A, 31'h7B};
    check_log("t5");

    // 6: header plus payload arriving during a stalled replay
    rdy_mode = 3;
    put(hdr(5));
    for (int i = 0; i < 5; i++) put(pay(31'(32'hF0 + i)));
    put(hdr(2)); put(pay(31'h99)); put(pay(31'h98));
    idle(3);
    check("t6_err_code", err_code, 3);
    check("t6_valid",    out_valid, 1);
    check("t6_data",     out_data,  31'hF0);
    rdy_mode = 0;
    idle(10);
    exp_q = '{31'hF0, 31'hF1, 31'hF2, 31'hF3, 31'hF4};
    check_log("t6");
    put(hdr(1)); put(pay(31'h5A));
    idle(4);
    exp_q = '{31'h5A};
    check_log("t6_after");

    // reset in the middle of a replay drops out_valid without a clock edge
    rdy_mode = 3;
    put(hdr(2)); put(pay(31'h61)); put(pay(31'h62));
    put_idle();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_error", error,     0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    dut_log.delete();

    // randomized stream against the model
    rdy_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 40)      put_idle();
      else if (r < 47) put(hdr(rand_len()));
      else             put(pay(31'($urandom)));
    end
    rdy_mode = 0;
    idle(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
